tcvc_arbiter: RTL and testbench

TCVC_ARBITER -- requirements
Module: tcvc_arbiter

---
 rtl/tcvc_pkg.sv | 21 ++
 rtl/tcvc_arbiter_rr_select.sv | 34 +++
 rtl/tcvc_arbiter.sv | 112 +++++++++++
 tb/tb_tcvc_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcvc_pkg.sv
// Shared tcvc constants: arbiter state encoding
// and the destination field carried in each word.
package tcvc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Destination index lives in the top DST_W bits of a word.
  localparam int DST_W = 2;
  localparam int NDST  = 4;

  function automatic logic [NDST-1:0] dst_onehot(
    input logic [DST_W-1:0] d
  );
    return NDST'(1) << d;
  endfunction

endpackage

// File: rtl/tcvc_arbiter_rr_select.sv
// Round-robin selector: first eligible source at or
// after the pointer, ascending with wrap.
module rr_select #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Scan N positions from ptr_i; N is a power of two,
  // so the index wraps by width.
  always_comb begin
    logic [PW-1:0] j;
    logic found;
    j     = '0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = ptr_i + PW'(k);
      if (!found && elig_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        found    = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/tcvc_arbiter.sv
// Round-robin arbiter forwarding words from N source
// FIFOs to 4 destination FIFOs with one cycle latency.
module tcvc_arbiter #(
  parameter int BW = 6,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [N-1:0]  src_empty,
  input  logic [N*BW-1:0] src_data,
  input  logic [3:0]    dst_almost_full,
  output logic [N-1:0]  src_pop,
  output logic [3:0]    dst_push,
  output logic [BW-1:0] dst_data,
  output logic          busy,
  output logic [7:0]    grant_cnt
);

  import tcvc_pkg::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [BW-1:0] data_q, data_d;
  logic          pend_q, pend_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [N-1:0]  elig;
  logic [N-1:0]  gnt;
  logic [PW-1:0] gidx;
  logic          any_elig;
  logic          any_ne;
  logic          grant;
  logic [BW-1:0] gword;

  for (genvar i = 0; i < N; i++) begin : g_elig
    assign elig[i] = ~src_empty[i] &
      ~dst_almost_full[src_data[i*BW+BW-DST_W +: DST_W]];
  end

  rr_select #(.N(N)) u_sel (
    .elig_i (elig),
    .ptr_i  (rr_q),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (any_elig)
  );

  assign any_ne = ~&src_empty;
  assign gword  = src_data[gidx*BW +: BW];

  // Next state and grant decision; only RUN grants.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && any_ne) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable || !any_ne) state_d = S_IDLE;
        else if (!any_elig)     state_d = S_HOLD;
        else                    grant   = 1'b1;
      end
      S_HOLD: begin
        if (!enable)       state_d = S_IDLE;
        else if (any_elig) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) grant = 1'b0;
  end

  // Capture the granted word and advance the pointer.
  always_comb begin
    rr_d   = rr_q;
    data_d = data_q;
    pend_d = grant;
    cnt_d  = cnt_q + {7'd0, |dst_push};
    if (grant) begin
      rr_d   = gidx + PW'(1);
      data_d = gword;
    end
  end

  // State, pointer, data and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign src_pop   = grant ? gnt : '0;
  assign dst_push  = (pend_q && !reset) ?
    dst_onehot(data_q[BW-1 -: DST_W]) : '0;
  assign dst_data  = data_q;
  assign busy      = (state_q == S_RUN);
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_tcvc_arbiter.sv
// Bench for tcvc_arbiter: source FIFOs as queues,
// directed scenarios plus a randomized model run.
module tb_tcvc_arbiter;

  localparam int BW = 6;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  src_empty;
  logic [N*BW-1:0] src_data;
  logic [3:0]    dst_almost_full;
  logic [N-1:0]  src_pop;
  logic [3:0]    dst_push;
  logic [BW-1:0] dst_data;
  logic          busy;
  logic [7:0]    grant_cnt;

  always #5 clk = ~clk;

  tcvc_arbiter #(.BW(BW), .N(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .dst_almost_full (dst_almost_full),
    .src_pop         (src_pop),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .busy            (busy),
    .grant_cnt       (grant_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] q[N][$];
  bit            rst_b;
  bit            en_b;
  logic [3:0]    af_b;

  // Reference model: 0 idle, 1 run, 2 hold.
  int            m_state;
  int            m_rr;
  int            m_cnt;
  bit            m_pend;
  logic [BW-1:0] m_data;
  int            g_exp;
  logic [N-1:0]  exp_pop;
  logic [3:0]    exp_push;

  function automatic bit elig(int i);
    logic [BW-1:0] h;
    if (q[i].size() == 0) return 1'b0;
    h = q[i][0];
    return !af_b[h[BW-1 -: 2]];
  endfunction

  function automatic logic [3:0] onehot4(logic [1:0] d);
    logic [3:0] r;
    r = 4'd0;
    r[d] = 1'b1;
    return r;
  endfunction

  // Drive this cycle's inputs, predict, go to negedge.
  task automatic tick_in();
    int j;
    for (int i = 0; i < N; i++) begin
      src_empty[i] = (q[i].size() == 0);
      src_data[i*BW +: BW] = (q[i].size() != 0) ?
        q[i][0] : BW'($urandom);
    end
    reset = rst_b;
    enable = en_b;
    dst_almost_full = af_b;
    g_exp = -1;
    if (!rst_b && en_b && m_state == 1)
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g_exp < 0 && elig(j)) g_exp = j;
      end
    exp_pop = '0;
    if (g_exp >= 0) exp_pop[g_exp] = 1'b1;
    exp_push = (m_pend && !rst_b) ?
      onehot4(m_data[BW-1 -: 2]) : 4'd0;
    @(negedge clk);
  endtask

  // Advance the model across the rising edge.
  task automatic tick_out();
    bit anyne, anyel;
    anyne = 1'b0;
    anyel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() != 0) anyne = 1'b1;
      if (elig(i)) anyel = 1'b1;
    end
    if (rst_b) begin
      m_state = 0; m_rr = 0; m_cnt = 0;
      m_pend = 1'b0; m_data = '0;
    end else begin
      if (exp_push != 0) m_cnt = (m_cnt + 1) % 256;
      m_pend = (g_exp >= 0);
      if (g_exp >= 0) begin
        m_data = q[g_exp].pop_front();
        m_rr = (g_exp + 1) % N;
      end
      case (m_state)
        0: if (en_b && anyne) m_state = 1;
        1: if (!en_b || !anyne) m_state = 0;
           else if (!anyel) m_state = 2;
        default: if (!en_b) m_state = 0;
                 else if (anyel) m_state = 1;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    rst_b = 1'b1; en_b = 1'b0; af_b = 4'd0;
    tick_in(); tick_out();
    tick_in(); tick_out();
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    q[0].push_back(6'h05);
    rst_b = 1'b1; en_b = 1'b1; af_b = 4'd0;
    tick_in();
    checks++;
    if (src_pop !== 4'd0 || dst_push !== 4'd0) begin
      errors++;
      $display("FAIL reset_strobes pop=%b push=%b want 0",
               src_pop, dst_push);
    end
    tick_out();
    tick_in();
    checks++;
    if (src_pop !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held pop=%b busy=%b want 0",
               src_pop, busy);
    end
    checks++;
    if (grant_cnt !== 8'd0 || dst_data !== 6'd0) begin
      errors++;
      $display("FAIL reset_regs cnt=%0d data=%h want 0",
               grant_cnt, dst_data);
    end
    tick_out();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    q[0].push_back(6'h05);
    en_b = 1'b1;
    tick_in();
    checks++;
    if (src_pop !== 4'd0) begin
      errors++;
      $display("FAIL single_c0 pop=%b want 0000", src_pop);
    end
    tick_out();
    tick_in();
    checks++;
    if (src_pop !== 4'b0001) begin
      errors++;
      $display("FAIL single_pop got %b want 0001", src_pop);
    end
    tick_out();
    tick_in();
    checks++;
    if (dst_push !== 4'b0001 || dst_data !== 6'h05) begin
      errors++;
      $display("FAIL single_push got %b/%h want 0001/05",
               dst_push, dst_data);
    end
    tick_out();
    tick_in();
    checks++;
    if (grant_cnt !== 8'd1 || dst_push !== 4'd0) begin
      errors++;
      $display("FAIL single_cnt cnt=%0d push=%b want 1/0000",
               grant_cnt, dst_push);
    end
    tick_out();
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < N; i++) begin
      q[i].push_back(BW'(2*i + 1));
      q[i].push_back(BW'(2*i + 2));
    end
    en_b = 1'b1;
    tick_in(); tick_out();
    for (int c = 0; c < 5; c++) begin
      tick_in();
      want = 4'd0;
      want[seq[c]] = 1'b1;
      checks++;
      if (src_pop !== want) begin
        errors++;
        $display("FAIL rr_order c%0d got %b want %b",
                 c, src_pop, want);
      end
      tick_out();
    end
  endtask

  task automatic test_hold();
    do_reset();
    q[1].push_back(6'h3A);
    en_b = 1'b1; af_b = 4'b1000;
    tick_in(); tick_out();
    tick_in(); tick_out();
    for (int c = 0; c < 2; c++) begin
      tick_in();
      checks++;
      if (busy !== 1'b0 || src_pop !== 4'd0) begin
        errors++;
        $display("FAIL hold_wait busy=%b pop=%b want 0/0000",
                 busy, src_pop);
      end
      tick_out();
    end
    af_b = 4'd0;
    tick_in();
    checks++;
    if (src_pop !== 4'd0) begin
      errors++;
      $display("FAIL hold_release pop=%b want 0000", src_pop);
    end
    tick_out();
    tick_in();
    checks++;
    if (src_pop !== 4'b0010) begin
      errors++;
      $display("FAIL hold_pop got %b want 0010", src_pop);
    end
    tick_out();
    tick_in();
    checks++;
    if (dst_push !== 4'b1000 || dst_data !== 6'h3A) begin
      errors++;
      $display("FAIL hold_push got %b/%h want 1000/3a",
               dst_push, dst_data);
    end
    tick_out();
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[2].push_back(6'h11);
    q[2].push_back(6'h12);
    en_b = 1'b1;
    tick_in(); tick_out();
    tick_in();
    checks++;
    if (src_pop !== 4'b0100) begin
      errors++;
      $display("FAIL rmid_pop got %b want 0100", src_pop);
    end
    tick_out();
    rst_b = 1'b1;
    tick_in();
    checks++;
    if (dst_push !== 4'd0 || src_pop !== 4'd0) begin
      errors++;
      $display("FAIL rmid_drop push=%b pop=%b want 0",
               dst_push, src_pop);
    end
    tick_out();
    rst_b = 1'b0;
    q[1].push_back(6'h01);
    q[3].push_back(6'h03);
    tick_in();
    checks++;
    if (grant_cnt !== 8'd0 || dst_data !== 6'd0) begin
      errors++;
      $display("FAIL rmid_regs cnt=%0d data=%h want 0",
               grant_cnt, dst_data);
    end
    tick_out();
    tick_in();
    checks++;
    if (src_pop !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_ptr got %b want 0010", src_pop);
    end
    tick_out();
  endtask

  task automatic test_enable_drop();
    do_reset();
    q[2].push_back(6'h2B);
    q[2].push_back(6'h2C);
    en_b = 1'b1;
    tick_in(); tick_out();
    tick_in();
    checks++;
    if (src_pop !== 4'b0100) begin
      errors++;
      $display("FAIL endrop_pop got %b want 0100", src_pop);
    end
    tick_out();
    en_b = 1'b0;
    tick_in();
    checks++;
    if (dst_push !== 4'b0100 || dst_data !== 6'h2B ||
        src_pop !== 4'd0) begin
      errors++;
      $display("FAIL endrop_push got %b/%h pop=%b want 0100/2b/0",
               dst_push, dst_data, src_pop);
    end
    tick_out();
    for (int c = 0; c < 2; c++) begin
      tick_in();
      checks++;
      if (src_pop !== 4'd0 || dst_push !== 4'd0 ||
          busy !== 1'b0) begin
        errors++;
        $display("FAIL endrop_idle pop=%b push=%b busy=%b want 0",
                 src_pop, dst_push, busy);
      end
      tick_out();
    end
  endtask

  task automatic test_wrap();
    int pushes = 0;
    int cyc = 0;
    do_reset();
    for (int w = 0; w < 256; w++)
      q[$urandom_range(0, N-1)].push_back(BW'($urandom));
    en_b = 1'b1;
    while (pushes < 256 && cyc < 800) begin
      tick_in();
      if (dst_push != 4'd0) pushes++;
      checks++;
      if (src_pop !== exp_pop) begin
        errors++;
        $display("FAIL wrap_pop cyc%0d got %b want %b",
                 cyc, src_pop, exp_pop);
      end
      tick_out();
      cyc++;
    end
    checks++;
    if (pushes != 256) begin
      errors++;
      $display("FAIL wrap_timeout pushes=%0d want 256", pushes);
    end
    tick_in();
    checks++;
    if (grant_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_cnt got %0d want 0", grant_cnt);
    end
    tick_out();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, N-1);
        if (q[r].size() < 6) q[r].push_back(BW'($urandom));
      end
      af_b = 4'($urandom) & 4'($urandom);
      en_b = ($urandom_range(0, 19) != 0);
      rst_b = ($urandom_range(0, 149) == 0);
      tick_in();
      checks++;
      if (src_pop !== exp_pop || dst_push !== exp_push) begin
        errors++;
        $display("FAIL rnd_strobe c%0d pop=%b/%b push=%b/%b",
                 c, src_pop, exp_pop, dst_push, exp_push);
      end
      checks++;
      if (dst_data !== m_data || grant_cnt !== 8'(m_cnt) ||
          busy !== (m_state == 1)) begin
        errors++;
        $display("FAIL rnd_regs c%0d data=%h/%h cnt=%0d/%0d busy=%b",
                 c, dst_data, m_data, grant_cnt, m_cnt, busy);
      end
      tick_out();
    end
    rst_b = 1'b0;
  endtask

  initial begin
    m_state = 0; m_rr = 0; m_cnt = 0;
    m_pend = 1'b0; m_data = '0;
    rst_b = 1'b1; en_b = 1'b0; af_b = 4'd0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_enable_drop();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
